pll_rst_seq: RTL
================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 20, number of CLK cycles PLL_RST is held high per PLL reset (1 us at 20 MHz).
REQ-002 Parameter LOCK_TIMEOUT, default 20000, number of CLK cycles WAIT_LOCK waits for lock before re-resetting the PLL.
REQ-003 Parameter STABLE_CYCLES, default 2000, number of contiguous locked CLK cycles required before reset release.
REQ-004 Parameter RELEASE_GAP, default 4, number of CLK cycles between RST_DSP release and RST_FAST release.
REQ-005 CLK  input  1  free-running 20 MHz reference clock, the same net that drives the PLL reference input (never a PLL output).
REQ-006 RST  input  1  asynchronous, active-high block reset.
REQ-007 LOCK  input  1  PLL lock indication, asynchronous to CLK.
REQ-008 SW_RST_REQ  input  1  CLK-synchronous single-cycle request to restart the whole sequence.
REQ-009 PLL_RST  output  1  active-high reset to the PLL RST pin.
REQ-010 RST_DSP  output  1  active-high reset for the 100 MHz CLKOP domain; that domain synchronises deassertion locally.
REQ-011 RST_FAST  output  1  active-high reset for the 200 MHz CLKOS domain; that domain synchronises deassertion locally.
REQ-012 READY  output  1  high only in state RUN.
REQ-013 LOSS_CNT  output  8  number of lock losses detected after reset release.
REQ-014 STATE  output  3  current state encoding, for debug.
REQ-015 One clock, CLK; RST is asynchronous and active-high.

Function
REQ-016 LOCK shall pass through a 2-flop synchroniser, giving LOCK_S with 2-cycle latency; only LOCK_S is used internally.
REQ-017 States shall be: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, REL_DSP=3, REL_FAST=4, RUN=5.
REQ-018 RESET_PLL: PLL_RST=1; after PLL_RST_CYCLES cycles the block shall go to WAIT_LOCK.
REQ-019 WAIT_LOCK: PLL_RST=0; when LOCK_S=1 it shall go to STABLE; after LOCK_TIMEOUT cycles without LOCK_S it shall go to RESET_PLL.
REQ-020 STABLE: when LOCK_S stays 1 for STABLE_CYCLES consecutive cycles it shall go to REL_DSP; any LOCK_S=0 cycle shall return it to WAIT_LOCK with the counter cleared.
REQ-021 REL_DSP: RST_DSP shall be driven 0 from the first cycle of this state; after RELEASE_GAP cycles the block shall go to REL_FAST.
REQ-022 REL_FAST: RST_FAST shall be driven 0 from the first cycle of this state; on the next cycle the block shall go to RUN.
REQ-023 RST_DSP and RST_FAST shall be 1 in RESET_PLL, WAIT_LOCK and STABLE; RST_FAST shall be 1 in REL_DSP.
REQ-024 Lock loss: LOCK_S=0 in REL_DSP, REL_FAST or RUN shall assert RST_DSP and RST_FAST on the next cycle, increment LOSS_CNT, and enter RESET_PLL.
REQ-025 SW_RST_REQ=1 in any state shall enter RESET_PLL on the next cycle with both resets asserted, without incrementing LOSS_CNT.
REQ-026 When SW_RST_REQ coincides with lock loss, SW_RST_REQ shall have priority and LOSS_CNT shall not increment.
REQ-027 LOSS_CNT shall saturate at 255 and never wrap.
REQ-028 All outputs shall be registered, with no combinational path from any input to any output.
REQ-029 All cycle counters shall clear on every state entry.

Reset
REQ-030 While RST=1: PLL_RST=1, RST_DSP=1, RST_FAST=1, READY=0, LOSS_CNT=0, state RESET_PLL, counters 0, synchroniser flops 0.
REQ-031 These values shall take effect asynchronously, without waiting for a CLK edge.
REQ-032 After RST deasserts, the sequence shall restart from RESET_PLL with a full PLL_RST_CYCLES pulse.
REQ-033 RST asserted mid-sequence shall reassert all resets immediately.

Configuration
REQ-034 Macro PLL_RST_SEQ_LOSS_CNT_EN: defined -> LOSS_CNT shall behave per REQ-024/027.
REQ-035 Macro PLL_RST_SEQ_LOSS_CNT_EN: undefined -> LOSS_CNT shall be constant 0, no counter logic shall be present, and the state behaviour shall be unchanged.

Verification
REQ-036 RST pulse, LOCK rises 100 cycles after PLL_RST falls -> PLL_RST high exactly 20 cycles; RST_DSP falls 2000+2 cycles after the LOCK edge (STABLE_CYCLES plus synchroniser latency); RST_FAST falls 4 cycles after RST_DSP; READY=1 one cycle after RST_FAST falls.
REQ-037 LOCK held 0 -> PLL_RST pulses of 20 cycles repeat every 20020 cycles; READY stays 0; LOSS_CNT=0.
REQ-038 LOCK drops for 1 cycle at cycle 1000 of STABLE -> return to WAIT_LOCK, full 2000-cycle count restarts, RST_DSP still 1.
REQ-039 In RUN, LOCK drops -> RST_DSP=RST_FAST=1 and READY=0 three cycles after the LOCK edge; LOSS_CNT 0->1; new PLL_RST pulse follows; 300 such losses -> LOSS_CNT=255.
REQ-040 SW_RST_REQ coincident with lock loss in RUN -> RESET_PLL entered, LOSS_CNT unchanged.
REQ-041 Build without PLL_RST_SEQ_LOSS_CNT_EN, repeat REQ-039 -> LOSS_CNT stays 0, all timing identical.

Source files
------------

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset / lock-qualify / staged domain reset release.
// Ports: clk_i ref clock, rst_i async reset, lock_i raw PLL lock,
//   sw_rst_req_i restart pulse; pll_rst_o, rst_dsp_o, rst_fast_o,
//   ready_o, loss_cnt_o[7:0], state_o[2:0] (all registered).
// Build option: define PLL_RST_SEQ_LOSS_CNT_EN to enable loss_cnt_o.
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 20,
  parameter int LOCK_TIMEOUT   = 20000,
  parameter int STABLE_CYCLES  = 2000,
  parameter int RELEASE_GAP    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lock_i,
  input  logic       sw_rst_req_i,
  output logic       pll_rst_o,
  output logic       rst_dsp_o,
  output logic       rst_fast_o,
  output logic       ready_o,
  output logic [7:0] loss_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_DSP   = 3'd3,
    REL_FAST  = 3'd4,
    RUN       = 3'd5
  } state_e;

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                         PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > RELEASE_GAP) ?
                         STABLE_CYCLES : RELEASE_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as locked cycle 1,
  // so STABLE itself only needs STABLE_CYCLES-1 more.
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP - 1);

  logic [1:0]    sync_q;
  logic          lock_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pll_rst_q;
  logic          rst_dsp_q;
  logic          rst_fast_q;
  logic          ready_q;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)                state_d = STABLE;
        else if (cnt_q == TO_LAST) state_d = RESET_PLL;
      end
      STABLE: begin
        if (!lock_s)                state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = REL_DSP;
      end
      REL_DSP: begin
        if (!lock_s)                state_d = RESET_PLL;
        else if (cnt_q == GAP_LAST) state_d = REL_FAST;
      end
      REL_FAST: begin
        if (!lock_s) state_d = RESET_PLL;
        else         state_d = RUN;
      end
      RUN: begin
        if (!lock_s) state_d = RESET_PLL;
      end
      default: state_d = RESET_PLL;
    endcase
    if (sw_rst_req_i) state_d = RESET_PLL;

    // Software restart re-enters RESET_PLL even from RESET_PLL.
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q || sw_rst_req_i || state_d == RUN)
      cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      pll_rst_q  <= 1'b1;
      rst_dsp_q  <= 1'b1;
      rst_fast_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], lock_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rst_q  <= (state_d == RESET_PLL);
      rst_dsp_q  <= (state_d inside {RESET_PLL, WAIT_LOCK, STABLE});
      rst_fast_q <= !(state_d inside {REL_FAST, RUN});
      ready_q    <= (state_d == RUN);
    end
  end

  assign pll_rst_o  = pll_rst_q;
  assign rst_dsp_o  = rst_dsp_q;
  assign rst_fast_o = rst_fast_q;
  assign ready_o    = ready_q;
  assign state_o    = state_q;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  logic       loss_evt;
  logic [7:0] loss_q;

  // A coincident software restart is not a lock loss.
  assign loss_evt = !sw_rst_req_i && !lock_s &&
                    (state_q inside {REL_DSP, REL_FAST, RUN});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loss_q <= '0;
    end else if (loss_evt && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt_o = loss_q;
`else
  assign loss_cnt_o = 8'd0;
`endif

endmodule
